knn_ctrl: RTL and testbench
===========================

# knn_ctrl

Top-level sequencer for one KNN classification job. It issues `start_calc` to the distance-calculation stage and waits for `done_calc`. It then waits for `distance_sort` to raise `valid_sort`, issues `start_vote` to the K-nearest vote stage, and captures the winning class. It also provides a start/busy/done handshake to the host, per-stage timeout with an error flag, and a job-latency counter.

## Interface
- `L`, default 5: log2 of the number of training points; passed through to the datapath, not used internally except for documentation.
- `TYPE_W`, default 3: class label width.
- `TIMEOUT`, default 1024: maximum cycles allowed per stage (CALC, SORT, VOTE); must be ≥2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `abort`  in  1  cancel the current job; returns to IDLE.
- `busy`  out  1  high in CALC, SORT, VOTE and DONE.
- `start_calc`  out  1  one-cycle pulse to the distance-calc stage.
- `done_calc`  in  1  distance-calc completion pulse (also feeds `distance_sort`).
- `valid_sort`  in  1  sorted-array valid from `distance_sort` (level or pulse).
- `start_vote`  out  1  one-cycle pulse to the vote stage.
- `valid_vote`  in  1  vote result valid.
- `vote_class`  in  `TYPE_W`  winning class from the vote stage.
- `class_out`  out  `TYPE_W`  registered result of the last completed job.
- `class_valid`  out  1  one-cycle pulse; `class_out` is new.
- `error`  out  1  sticky timeout flag.
- `cycle_count`  out  16  latency of the last completed job, in cycles.

## Operation
- FSM states and transitions:
  - IDLE → CALC on `start` && !`abort`.
  - CALC → SORT on `done_calc`.
  - SORT → VOTE on a rising edge of `valid_sort`, i.e. `valid_sort` = 1 and registered `valid_sort_q` = 0.
  - VOTE → DONE on `valid_vote`.
  - DONE → IDLE unconditionally.
- All outputs are registered.
  - `start_calc` is high only in the first cycle of CALC.
  - `start_vote` is high only in the first cycle of VOTE.
  - `class_valid` is high for the single DONE cycle.
- `valid_sort_q` updates every cycle in every state. Edge detection therefore ignores a `valid_sort` level held over from a previous job.
- `class_out` loads `vote_class` on the edge that enters DONE and holds until the next such load.
- `error` behaviour:
  - Cleared on the edge that accepts `start` (IDLE → CALC).
  - Set on timeout.
  - Otherwise holds.
- Stage timer:
  - Zero on entry to CALC, SORT or VOTE; increments each cycle in those states.
  - If timer = `TIMEOUT`-1 and the stage's completion event is absent, the FSM goes to IDLE, `error` is set, and no `class_valid` is issued.
  - A completion event in the same cycle as the timeout wins: the FSM advances normally and `error` is not set.
- Latency counter:
  - Cleared on entry to CALC; increments in CALC, SORT and VOTE; saturates at 0xFFFF.
  - Copied to `cycle_count` on entry to DONE only. Aborted or timed-out jobs leave `cycle_count` unchanged.
- `abort` in CALC, SORT, VOTE or DONE goes to IDLE on the next edge and suppresses any pending `class_valid`. `error`, `class_out` and `cycle_count` are unchanged. In IDLE, `abort` has priority over `start`.
- Stray inputs are ignored:
  - `start` while busy.
  - `done_calc` outside CALC.
  - `valid_vote` outside VOTE.
- Reset:
  - State IDLE.
  - `busy`, `start_calc`, `start_vote`, `class_valid`, `error` = 0.
  - `class_out` = 0; `cycle_count` = 0; timers = 0; `valid_sort_q` = 0.
  - Reset mid-job discards the job without emitting any pulse.

## Timing
- `start` sampled at edge t0 → CALC. `busy` = 1 and `start_calc` = 1 during cycle t0→t0+1.
- `done_calc` sampled at edge t1 → SORT. Earliest t1 = t0+1.
- `valid_sort` rising, sampled at t2 → VOTE. `start_vote` = 1 during cycle t2→t2+1.
- `valid_vote` sampled at t3 → DONE. `class_out`, `cycle_count` = t3−t0 and `class_valid` = 1 are visible after t3.
- IDLE after t3+1. `busy` = 0 after t3+1, and a new `start` can be accepted at edge t3+1.
- Minimum job, with all responses immediate: t3−t0 = 3 and `cycle_count` = 3.
- Timeout fires at the edge ending the `TIMEOUT`-th cycle of a stage.

## Test plan
- Nominal job:
  - Stimulus: reset, then `start` at t0; `done_calc` at t0+4; `valid_sort` rises at t0+10; `valid_vote` with `vote_class` = 5 at t0+13.
  - Required: `start_calc` pulse at cycle 1 and `start_vote` pulse after t0+10; `class_out` = 5, `class_valid` one cycle, `cycle_count` = 13, `busy` falls after t0+14.
- Stale `valid_sort`:
  - Stimulus: hold `valid_sort` = 1 from before `start` through SORT, then drop it and raise it again 3 cycles later.
  - Required: VOTE is entered only on the re-rise.
- Timeout (`TIMEOUT` = 8):
  - Stimulus: `start`, never `done_calc`.
  - Required: `error` = 1 and IDLE after 8 CALC cycles, no `class_valid`.
  - Follow-up: the next `start` clears `error`.
  - Variant: `done_calc` exactly in cycle 8 → SORT, `error` = 0.
- Abort:
  - Stimulus: `abort` in SORT.
  - Required: IDLE next edge; `class_out` and `cycle_count` keep their previous job's values.
  - Variant: `abort` with `start` in IDLE → stays IDLE.
- Ignored inputs:
  - Stimulus: `start` pulses during VOTE and `done_calc` during SORT.
  - Required: no state change and no extra `start_calc`.
- Reset mid-job:
  - Stimulus: `rst` during VOTE with `valid_vote` asserted the same cycle.
  - Required: all outputs 0 after the edge and no `class_valid`.

Source files
------------

// File: rtl/knn_ctrl_if.sv
// Host and stage handshake bundle for the KNN job sequencer.
// The master side drives requests and stage responses; the slave side is the controller.
interface knn_ctrl_if #(
    parameter int TYPE_W = 3
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              start_calc;
    logic              done_calc;
    logic              valid_sort;
    logic              start_vote;
    logic              valid_vote;
    logic [TYPE_W-1:0] vote_class;
    logic [TYPE_W-1:0] class_out;
    logic              class_valid;
    logic              error;
    logic [15:0]       cycle_count;

    modport master (
        output start, abort, done_calc, valid_sort, valid_vote, vote_class,
        input  busy, start_calc, start_vote, class_out, class_valid,
        input  error, cycle_count
    );

    modport slave (
        input  start, abort, done_calc, valid_sort, valid_vote, vote_class,
        output busy, start_calc, start_vote, class_out, class_valid,
        output error, cycle_count
    );
endinterface

// File: rtl/knn_ctrl.sv
// Sequencer for one KNN classification job: calc -> sort -> vote -> result.
// Provides host handshake, per-stage timeout, sticky error and job latency.
module knn_ctrl #(
    parameter int L       = 5,
    parameter int TYPE_W  = 3,
    parameter int TIMEOUT = 1024
) (
    input logic      clk,
    input logic      rst,
    knn_ctrl_if.slave bus
);
    if (TIMEOUT < 2 || L < 1) begin : g_bad_param
        $error("knn_ctrl: TIMEOUT must be >= 2 and L >= 1");
    end

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_SORT,
        S_VOTE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    state_t        adv;
    logic [TW-1:0] timer;
    logic [15:0]   lat;
    logic [15:0]   lat_inc;
    logic          vs_q;
    logic          ev;
    logic          in_stage;
    logic          accept;
    logic          tmo;

    assign in_stage = (state == S_CALC) || (state == S_SORT) ||
                      (state == S_VOTE);
    assign lat_inc  = (lat == 16'hFFFF) ? lat : lat + 16'd1;

    always_comb begin
        nxt    = state;
        adv    = state;
        ev     = 1'b0;
        accept = 1'b0;
        tmo    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    nxt    = S_CALC;
                    accept = 1'b1;
                end
            end
            S_CALC: begin
                ev  = bus.done_calc;
                adv = S_SORT;
            end
            S_SORT: begin
                ev  = bus.valid_sort && !vs_q;
                adv = S_VOTE;
            end
            S_VOTE: begin
                ev  = bus.valid_vote;
                adv = S_DONE;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        // completion in the timeout cycle still advances normally
        if (in_stage) begin
            if (ev) begin
                nxt = adv;
            end else if (timer == TO_LAST) begin
                nxt = S_IDLE;
                tmo = 1'b1;
            end
        end
        if (bus.abort && state != S_IDLE) begin
            nxt = S_IDLE;
            tmo = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
            lat   <= '0;
            vs_q  <= 1'b0;
        end else begin
            vs_q <= bus.valid_sort;
            if (in_stage && nxt == state) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
            if (accept) begin
                lat <= '0;
            end else if (in_stage) begin
                lat <= lat_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.busy        <= 1'b0;
            bus.start_calc  <= 1'b0;
            bus.start_vote  <= 1'b0;
            bus.class_valid <= 1'b0;
            bus.error       <= 1'b0;
            bus.class_out   <= '0;
            bus.cycle_count <= '0;
        end else begin
            bus.busy        <= (nxt != S_IDLE);
            bus.start_calc  <= accept;
            bus.start_vote  <= (state == S_SORT) && (nxt == S_VOTE);
            bus.class_valid <= (state == S_VOTE) && (nxt == S_DONE);
            if (accept) begin
                bus.error <= 1'b0;
            end else if (tmo) begin
                bus.error <= 1'b1;
            end
            if (state == S_VOTE && nxt == S_DONE) begin
                bus.class_out   <= bus.vote_class;
                bus.cycle_count <= lat_inc;
            end
        end
    end
endmodule

// File: tb/tb_knn_ctrl.sv
// Directed bench for knn_ctrl with TIMEOUT=8.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_knn_ctrl;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_sc  = 0;
    int   n_sv  = 0;
    int   n_cv  = 0;
    int   sc0, sv0, cv0;

    knn_ctrl_if #(.TYPE_W(TW)) bus ();

    knn_ctrl #(
        .L      (5),
        .TYPE_W (TW),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.start_calc === 1'b1) n_sc++;
            if (bus.start_vote === 1'b1) n_sv++;
            if (bus.class_valid === 1'b1) n_cv++;
        end
    endtask

    task automatic snap();
        sc0 = n_sc;
        sv0 = n_sv;
        cv0 = n_cv;
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.done_calc  = 1'b0;
        bus.valid_sort = 1'b0;
        bus.valid_vote = 1'b0;
        bus.vote_class = '0;
        tick(2);
        rst = 1'b0;
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_sc", bus.start_calc, 0);
        check("rst_sv", bus.start_vote, 0);
        check("rst_cv", bus.class_valid, 0);
        check("rst_err", bus.error, 0);
        check("rst_class", bus.class_out, 0);
        check("rst_cnt", bus.cycle_count, 0);

        // nominal job
        snap();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("nom_busy", bus.busy, 1);
        check("nom_sc", bus.start_calc, 1);
        tick();
        check("nom_sc_end", bus.start_calc, 0);
        tick(2);
        bus.done_calc = 1'b1;
        tick();
        bus.done_calc = 1'b0;
        tick(5);
        check("nom_sv_early", n_sv - sv0, 0);
        bus.valid_sort = 1'b1;
        tick();
        check("nom_sv", bus.start_vote, 1);
        tick();
        check("nom_sv_end", bus.start_vote, 0);
        bus.valid_sort = 1'b0;
        tick();
        bus.valid_vote = 1'b1;
        bus.vote_class = 3'd5;
        tick();
        bus.valid_vote = 1'b0;
        check("nom_cv", bus.class_valid, 1);
        check("nom_class", bus.class_out, 5);
        check("nom_cnt", bus.cycle_count, 13);
        check("nom_busy_done", bus.busy, 1);
        tick();
        check("nom_cv_end", bus.class_valid, 0);
        check("nom_busy_end", bus.busy, 0);
        check("nom_cv_count", n_cv - cv0, 1);
        check("nom_sc_count", n_sc - sc0, 1);

        // minimum-length job
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.done_calc = 1'b1;
        tick();
        bus.done_calc = 1'b0;
        bus.valid_sort = 1'b1;
        tick();
        bus.valid_sort = 1'b0;
        bus.valid_vote = 1'b1;
        bus.vote_class = 3'd1;
        tick();
        bus.valid_vote = 1'b0;
        check("min_cv", bus.class_valid, 1);
        check("min_cnt", bus.cycle_count, 3);
        check("min_class", bus.class_out, 1);
        tick();

        // stale valid_sort, stray done_calc in SORT, stray start in VOTE
        snap();
        bus.valid_sort = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.done_calc = 1'b1;
        tick();
        tick();
        tick();
        bus.done_calc = 1'b0;
        check("stale_busy", bus.busy, 1);
        check("stale_no_sv", n_sv - sv0, 0);
        bus.valid_sort = 1'b0;
        tick(2);
        check("stale_no_sv2", n_sv - sv0, 0);
        bus.valid_sort = 1'b1;
        tick();
        check("stale_sv", bus.start_vote, 1);
        bus.start = 1'b1;
        tick(2);
        bus.start = 1'b0;
        check("stray_busy", bus.busy, 1);
        check("stray_sc", n_sc - sc0, 1);
        check("stray_cv", n_cv - cv0, 0);
        bus.valid_vote = 1'b1;
        bus.vote_class = 3'd2;
        tick();
        bus.valid_vote = 1'b0;
        check("stale_cv", bus.class_valid, 1);
        check("stale_class", bus.class_out, 2);
        check("stale_cnt", bus.cycle_count, 9);
        tick();
        check("stale_idle", bus.busy, 0);
        bus.valid_sort = 1'b0;

        // abort in SORT
        snap();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.done_calc = 1'b1;
        tick();
        bus.done_calc = 1'b0;
        tick();
        bus.abort = 1'b1;
        bus.valid_sort = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.valid_sort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_class", bus.class_out, 2);
        check("abort_cnt", bus.cycle_count, 9);
        check("abort_sv", n_sv - sv0, 0);
        tick(2);
        check("abort_cv", n_cv - cv0, 0);

        // abort with start in IDLE
        snap();
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abst_busy", bus.busy, 0);
        check("abst_sc", n_sc - sc0, 0);

        // CALC timeout
        snap();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(7);
        check("to_busy_pre", bus.busy, 1);
        check("to_err_pre", bus.error, 0);
        tick();
        check("to_busy", bus.busy, 0);
        check("to_err", bus.error, 1);
        check("to_cnt", bus.cycle_count, 9);
        check("to_cv", n_cv - cv0, 0);
        tick(2);
        check("to_err_hold", bus.error, 1);

        // restart clears error; done_calc lands in the last CALC cycle
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("to_clr", bus.error, 0);
        tick(7);
        bus.done_calc = 1'b1;
        tick();
        bus.done_calc = 1'b0;
        check("edge_busy", bus.busy, 1);
        check("edge_err", bus.error, 0);
        bus.valid_sort = 1'b1;
        tick();
        bus.valid_sort = 1'b0;
        check("edge_sv", bus.start_vote, 1);
        bus.valid_vote = 1'b1;
        bus.vote_class = 3'd7;
        tick();
        bus.valid_vote = 1'b0;
        check("edge_class", bus.class_out, 7);
        check("edge_cnt", bus.cycle_count, 10);
        tick();

        // reset during VOTE with valid_vote asserted
        snap();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.done_calc = 1'b1;
        tick();
        bus.done_calc = 1'b0;
        bus.valid_sort = 1'b1;
        tick();
        bus.valid_sort = 1'b0;
        bus.valid_vote = 1'b1;
        bus.vote_class = 3'd3;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.valid_vote = 1'b0;
        check("mrst_busy", bus.busy, 0);
        check("mrst_cv", bus.class_valid, 0);
        check("mrst_sv", bus.start_vote, 0);
        check("mrst_class", bus.class_out, 0);
        check("mrst_cnt", bus.cycle_count, 0);
        check("mrst_err", bus.error, 0);
        tick(2);
        check("mrst_cv_count", n_cv - cv0, 0);
        check("mrst_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
